// File: rtl/uart_pkg.sv
// Framing types and helpers shared by the
// configurable UART transmitter and receiver.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'b00,
    PAR_EVEN = 2'b01,
    PAR_ODD  = 2'b10
  } parity_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_t;

  localparam int MIN_DATA_BITS = 5;
  localparam int MIN_DIV       = 2;

  function automatic logic [3:0] eff_data_bits(
    input logic [3:0] raw,
    input logic [3:0] max_bits
  );
    logic [3:0] r;
    r = raw;
    if (raw < 4'(MIN_DATA_BITS)) r = 4'(MIN_DATA_BITS);
    if (raw > max_bits)          r = max_bits;
    return r;
  endfunction

endpackage

// File: rtl/uart_tx_cfg_if.sv
// Byte-level valid/ready handshake between an
// upstream word source and the UART transmitter.
interface uart_tx_cfg_if #(
  parameter int DATA_BITS = 8
);
  logic                 s_valid;
  logic                 s_ready;
  logic [DATA_BITS-1:0] s_data;

  modport master (
    output s_valid,
    output s_data,
    input  s_ready
  );

  modport slave (
    input  s_valid,
    input  s_data,
    output s_ready
  );
endinterface

// File: rtl/uart_baud_tick.sv
// Bit-period timer: counts 0..div-1 while enabled and
// pulses tick on the last clock of each period.
module uart_baud_tick #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [DIV_WIDTH-1:0] div,
  output logic                 tick
);

  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;

  assign tick = en && (cnt_q == div - DIV_WIDTH'(1));

  always_comb begin
    cnt_d = '0;
    if (en && !tick) cnt_d = cnt_q + DIV_WIDTH'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// Runtime-configurable UART transmitter: 5..DATA_BITS
// data bits, none/even/odd parity, 1 or 2 stop bits.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DIV_WIDTH-1:0] cfg_div,
  input  logic [3:0]           cfg_data_bits,
  input  logic [1:0]           cfg_parity,
  input  logic                 cfg_stop2,
  uart_tx_cfg_if.slave         s,
  output logic                 busy,
  output logic                 tx
);

  tx_state_t            state_q, state_d;
  logic [DATA_BITS-1:0] sh_q, sh_d;
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic [3:0]           nbits_q, nbits_d;
  parity_t              par_q, par_d;
  logic                 stop2_q, stop2_d;
  logic                 acc_q, acc_d;
  logic [3:0]           bit_q, bit_d;
  logic                 tx_q, tx_d;

  logic tick;
  logic last_stop;
  logic accept;
  logic par_bit;

  uart_baud_tick #(
    .DIV_WIDTH(DIV_WIDTH)
  ) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (state_q != ST_IDLE),
    .div  (div_q),
    .tick (tick)
  );

  assign last_stop = (state_q == ST_STOP) && tick
                  && (bit_q == {3'b000, stop2_q});
  assign s.s_ready = rst_n
                  && ((state_q == ST_IDLE) || last_stop);
  assign accept    = s.s_valid && s.s_ready;
  assign busy      = (state_q != ST_IDLE);
  assign tx        = tx_q;

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    div_d   = div_q;
    nbits_d = nbits_q;
    par_d   = par_q;
    stop2_d = stop2_q;
    acc_d   = acc_q;
    bit_d   = bit_q;

    if (accept) begin
      state_d = ST_START;
      sh_d    = s.s_data;
      div_d   = (cfg_div < DIV_WIDTH'(MIN_DIV))
              ? DIV_WIDTH'(MIN_DIV) : cfg_div;
      nbits_d = eff_data_bits(cfg_data_bits,
                              4'(DATA_BITS));
      par_d   = (cfg_parity == 2'b11)
              ? PAR_NONE : parity_t'(cfg_parity);
      stop2_d = cfg_stop2;
      acc_d   = 1'b0;
      bit_d   = '0;
    end else if (tick) begin
      case (state_q)
        ST_START: begin
          state_d = ST_DATA;
          bit_d   = '0;
        end
        ST_DATA: begin
          acc_d = acc_q ^ sh_q[0];
          sh_d  = sh_q >> 1;
          if (bit_q == nbits_q - 4'd1) begin
            bit_d   = '0;
            state_d = (par_q == PAR_NONE)
                    ? ST_STOP : ST_PARITY;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
        ST_PARITY: begin
          state_d = ST_STOP;
          bit_d   = '0;
        end
        ST_STOP: begin
          if (last_stop) begin
            state_d = ST_IDLE;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Line level follows the next state so tx is a flop.
  assign par_bit = (par_d == PAR_ODD) ? ~acc_d : acc_d;

  always_comb begin
    tx_d = 1'b1;
    unique case (1'b1)
      state_d == ST_START:  tx_d = 1'b0;
      state_d == ST_DATA:   tx_d = sh_d[0];
      state_d == ST_PARITY: tx_d = par_bit;
      default:              tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sh_q    <= '0;
      div_q   <= DIV_WIDTH'(MIN_DIV);
      nbits_q <= 4'(MIN_DATA_BITS);
      par_q   <= PAR_NONE;
      stop2_q <= 1'b0;
      acc_q   <= 1'b0;
      bit_q   <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      div_q   <= div_d;
      nbits_q <= nbits_d;
      par_q   <= par_d;
      stop2_q <= stop2_d;
      acc_q   <= acc_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg: framing, parity,
// back-to-back, clamping, config isolation, reset.
module tb_uart_tx_cfg;
  import uart_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [15:0] cfg_div;
  logic [3:0]  cfg_data_bits;
  logic [1:0]  cfg_parity;
  logic        cfg_stop2;
  logic        busy8, tx8;
  logic        busy9, tx9;

  int total = 0;
  int bad   = 0;

  uart_tx_cfg_if #(.DATA_BITS(8)) if8();
  uart_tx_cfg_if #(.DATA_BITS(9)) if9();

  uart_tx_cfg #(
    .DATA_BITS(8),
    .DIV_WIDTH(16)
  ) dut8 (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg_div      (cfg_div),
    .cfg_data_bits(cfg_data_bits),
    .cfg_parity   (cfg_parity),
    .cfg_stop2    (cfg_stop2),
    .s            (if8),
    .busy         (busy8),
    .tx           (tx8)
  );

  uart_tx_cfg #(
    .DATA_BITS(9),
    .DIV_WIDTH(16)
  ) dut9 (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg_div      (cfg_div),
    .cfg_data_bits(cfg_data_bits),
    .cfg_parity   (cfg_parity),
    .cfg_stop2    (cfg_stop2),
    .s            (if9),
    .busy         (busy9),
    .tx           (tx9)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called in the first cycle after acceptance; vec[i]
  // is the expected level of bit period i (0 = start).
  task automatic check_frame(
    input string       tag,
    input bit          use9,
    input logic [31:0] vec,
    input int          nb,
    input int          dv,
    input bit          tail
  );
    int len;
    len = nb * dv;
    for (int j = 1; j <= len; j++) begin
      chk($sformatf("%s_tx%0d", tag, j),
          32'(use9 ? tx9 : tx8),
          32'(vec[(j-1)/dv]));
      chk($sformatf("%s_busy%0d", tag, j),
          32'(use9 ? busy9 : busy8), 32'd1);
      chk($sformatf("%s_rdy%0d", tag, j),
          32'(use9 ? if9.s_ready : if8.s_ready),
          (j == len) ? 32'd1 : 32'd0);
      step();
    end
    if (tail) begin
      chk({tag, "_idle_tx"},
          32'(use9 ? tx9 : tx8), 32'd1);
      chk({tag, "_idle_busy"},
          32'(use9 ? busy9 : busy8), 32'd0);
      chk({tag, "_idle_rdy"},
          32'(use9 ? if9.s_ready : if8.s_ready), 32'd1);
    end
  endtask

  task automatic send8(input logic [7:0] d);
    if8.s_data  = d;
    if8.s_valid = 1'b1;
    step();
    if8.s_valid = 1'b0;
  endtask

  task automatic set_cfg(
    input logic [15:0] dv,
    input logic [3:0]  nb,
    input logic [1:0]  par,
    input logic        st2
  );
    cfg_div       = dv;
    cfg_data_bits = nb;
    cfg_parity    = par;
    cfg_stop2     = st2;
  endtask

  initial begin
    rst_n       = 1'b0;
    if8.s_valid = 1'b0;
    if8.s_data  = '0;
    if9.s_valid = 1'b0;
    if9.s_data  = '0;
    set_cfg(16'd4, 4'd8, PAR_NONE, 1'b0);

    step();
    chk("rst_tx", 32'(tx8), 32'd1);
    chk("rst_busy", 32'(busy8), 32'd0);
    chk("rst_rdy", 32'(if8.s_ready), 32'd0);
    chk("rst_tx9", 32'(tx9), 32'd1);
    step();
    rst_n = 1'b1;
    #1;
    chk("post_rst_rdy", 32'(if8.s_ready), 32'd1);
    chk("post_rst_rdy9", 32'(if9.s_ready), 32'd1);
    step();

    // 8N1, 0xA5, div 4
    set_cfg(16'd4, 4'd8, PAR_NONE, 1'b0);
    send8(8'hA5);
    check_frame("8n1", 1'b0,
                32'(10'b1101001010), 10, 4, 1'b1);
    step();

    // 7E2, 0x13, div 3
    set_cfg(16'd3, 4'd7, PAR_EVEN, 1'b1);
    send8(8'h13);
    check_frame("7e2", 1'b0,
                32'(11'b11100100110), 11, 3, 1'b1);
    step();

    // 9O1, 0x1FF, div 2 on the 9-bit instance
    set_cfg(16'd2, 4'd9, PAR_ODD, 1'b0);
    if9.s_data  = 9'h1FF;
    if9.s_valid = 1'b1;
    step();
    if9.s_valid = 1'b0;
    check_frame("9o1", 1'b1,
                32'(12'b101111111110), 12, 2, 1'b1);
    step();

    // back-to-back 0x55 then 0xAA, div 2
    set_cfg(16'd2, 4'd8, PAR_NONE, 1'b0);
    if8.s_data  = 8'h55;
    if8.s_valid = 1'b1;
    step();
    if8.s_data = 8'hAA;
    check_frame("b2b_a", 1'b0,
                32'(10'b1010101010), 10, 2, 1'b0);
    if8.s_valid = 1'b0;
    check_frame("b2b_b", 1'b0,
                32'(10'b1101010100), 10, 2, 1'b1);
    step();

    // div 0 -> 2, 3 bits -> 5, parity 2'b11 -> none
    set_cfg(16'd0, 4'd3, 2'b11, 1'b0);
    send8(8'hF6);
    check_frame("clamp", 1'b0,
                32'(7'b1101100), 7, 2, 1'b1);
    step();

    // 15 bits -> 8; cfg changes mid-frame are ignored
    set_cfg(16'd2, 4'd15, PAR_NONE, 1'b0);
    send8(8'h0F);
    set_cfg(16'd5, 4'd5, PAR_EVEN, 1'b1);
    check_frame("iso", 1'b0,
                32'(10'b1000011110), 10, 2, 1'b1);
    step();

    // reset during data bit 3 of a 0x00 frame
    set_cfg(16'd4, 4'd8, PAR_NONE, 1'b0);
    send8(8'h00);
    repeat (17) step();
    chk("mid_pre_tx", 32'(tx8), 32'd0);
    chk("mid_pre_busy", 32'(busy8), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_tx", 32'(tx8), 32'd1);
    chk("mid_rst_busy", 32'(busy8), 32'd0);
    chk("mid_rst_rdy", 32'(if8.s_ready), 32'd0);
    step();
    step();
    rst_n = 1'b1;
    #1;
    chk("mid_rel_rdy", 32'(if8.s_ready), 32'd1);
    chk("mid_rel_tx", 32'(tx8), 32'd1);
    step();
    chk("mid_hold_tx", 32'(tx8), 32'd1);
    send8(8'h3C);
    check_frame("after_rst", 1'b0,
                32'(10'b1001111000), 10, 4, 1'b1);
    step();

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_cfg.md
# uart_tx_cfg

Parametrised, runtime-configurable UART transmitter. It is the successor to the fixed 8N1 transmitter. It supports 5..DATA_BITS data bits, none/even/odd parity, 1 or 2 stop bits, and a runtime baud divisor, behind a valid/ready byte interface. It sits between a TX FIFO or register block and the serial pin, and shares framing types with the matching receiver.

## Interface
- DATA_BITS, 8: maximum data bits per frame, legal range 5..9.
- DIV_WIDTH, 16: width of the baud divisor input.
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- cfg_div  in  DIV_WIDTH  clocks per bit. Values below 2 are treated as 2.
- cfg_data_bits  in  4  data bits per frame. Values below 5 clamp to 5; values above DATA_BITS clamp to DATA_BITS.
- cfg_parity  in  2  parity_t: PAR_NONE, PAR_EVEN, PAR_ODD. Encoding 2'b11 is treated as PAR_NONE.
- cfg_stop2  in  1  0 selects 1 stop bit; 1 selects 2 stop bits.
- s_valid  in  1  a data word is offered.
- s_ready  out  1  the transmitter can accept a word this cycle.
- s_data  in  DATA_BITS  word to send, LSB first. Bits at or above the effective data-bit count are ignored.
- busy  out  1  a frame is in progress.
- tx  out  1  serial line, idle high.

## Operation
- Accept rule: a word is accepted on a rising edge where s_valid && s_ready.
- At acceptance, s_data and all cfg_* inputs are captured into a frame register. Later changes to cfg_* do not affect the frame in flight.
- State machine (tx_state_t): IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
  - START: tx=0.
  - DATA: tx = the current shift-register LSB. The register shifts right each bit period.
  - PARITY: entered only when parity is enabled. Even parity sends the XOR of the effective data bits; odd parity sends its inverse.
  - STOP: tx=1 for 1 or 2 bit periods.
- Every bit period lasts exactly div_eff clocks. It is timed by a baud counter that counts 0..div_eff-1 and restarts on each bit boundary.
- Back-to-back handshake: s_ready=1 in IDLE and on the final clock of the final stop bit. Acceptance on that final clock goes directly to START, so frames follow with zero idle gap.
- busy=1 in every state except IDLE.
- Reset, including mid-frame: tx=1, state IDLE, counters 0, busy=0. s_ready reads 0 while rst_n is low. There is no partial-frame completion.
- s_valid while s_ready=0 is ignored. Holding a word until it is accepted is the upstream's responsibility.

## Timing
- Acceptance at edge k: tx falls in the cycle after edge k and stays 0 for div_eff cycles.
- Data bit i occupies cycles k+1+div_eff*(1+i) .. k+div_eff*(2+i).
- Frame length L = div_eff*(1 + n + p + s), where n is the effective data-bit count, p is 0 or 1 for parity, and s is 1 or 2 stop bits.
- s_ready is high in cycle k+L. The earliest next start bit is in cycle k+L+1.
- All outputs are registered except s_ready and busy, which decode the registered state and counters.
- Baud counter width is DIV_WIDTH. Bit counter width is 4 bits and counts bits within the current phase.

## Structure
- Package uart_pkg holds:
  - parity_t
  - tx_state_t
  - constants MIN_DATA_BITS=5 and MIN_DIV=2
  - a function computing effective data bits from the raw config value
  - The receiver shares this package.
- Sub-module uart_baud_tick (DIV_WIDTH). It takes clk, rst_n, a run enable and a divisor, and outputs a one-cycle tick on the last clock of each bit period.
- The top level holds the FSM, the frame register, the shift register and the parity accumulator.

## Test plan
- Reset values and 8N1: DATA_BITS=8, div=4, s_data=0xA5, parity none, 1 stop bit. tx is 0 for cycles 1-4, then data bits 1,0,1,0,0,1,0,1 for 4 cycles each, then 1. L=40, and busy is high for exactly 40 cycles.
- 7E2 framing: div=3, data_bits=7, even parity, 2 stop bits, s_data=0x13. Data bits are 1,1,0,0,1,0,0, the parity bit is 1, the stop bits last 6 cycles, and L=33.
- Odd parity and 9 data bits: DATA_BITS=9, data_bits=9, s_data=0x1FF, odd parity. The parity bit is 0 and L = div*12.
- Back-to-back frames: s_valid held high with 0x55 then 0xAA, div=2. The second start bit begins in the cycle right after the first frame's last stop clock, with no idle-high gap.
- Clamping and config isolation:
  - cfg_div=0 gives 2-cycle bits.
  - cfg_data_bits=3 sends 5 bits.
  - Changing cfg_* mid-frame does not alter the current frame.
- Mid-frame reset: assert rst_n=0 during data bit 3. tx=1 and busy=0 immediately. After release, s_ready=1, and a new 0x3C frame transmits correctly.
